// File: rtl/layer2_pool_sched_if.sv
// Handshake bundle between the layer-2 pool scheduler and the feature buffer,
// window packer, pool array and pool output buffer.
interface layer2_pool_sched_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        slot;
    logic              slot_vld;
    logic              pool_start;
    logic              pool_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              err;

    modport master (
        input  start, pool_ready,
        output busy, done, rd_en, rd_addr, slot, slot_vld,
               pool_start, wr_en, wr_addr, err
    );

    modport slave (
        output start, pool_ready,
        input  busy, done, rd_en, rd_addr, slot, slot_vld,
               pool_start, wr_en, wr_addr, err
    );
endinterface

// File: rtl/layer2_pool_sched.sv
// Layer-2 2x2/stride-2 max-pool sequencer: reads each window, kicks the pool array,
// writes the pooled pixel. Optional WAIT_RDY timeout under `POOL_SCHED_TIMEOUT_EN.
module layer2_pool_sched #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 8
`ifdef POOL_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input logic                 clk_in,
    input logic                 rst,
    layer2_pool_sched_if.master bus
);

    // state    | meaning
    // IDLE     | waiting for start
    // RD0..RD3 | read window pixel TL, TR, BL, BR
    // LAST     | BR pixel data returning from the buffer
    // POOL     | pool_start pulse
    // WAIT_RDY | waiting for pool_ready (or timeout)
    // WR       | write pooled pixel, advance window
    // FIN      | raise done, drop busy
    typedef enum logic [3:0] {
        IDLE, RD0, RD1, RD2, RD3, LAST, POOL, WAIT_RDY, WR, FIN
    } state_t;

    localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] WIN_C = ADDR_W'(IMG_W / 2);
    localparam logic [ADDR_W-1:0] WIN_R = ADDR_W'(IMG_H / 2);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] win_row;
    logic [ADDR_W-1:0] win_col;
    logic [ADDR_W-1:0] out_idx;
    logic              slot_vld_q;
    logic [1:0]        slot_q;
    logic              busy_q;
    logic              done_q;

    logic              rd_en;
    logic [1:0]        rd_k;
    logic              pool_start;
    logic              wr_en;
    logic              col_more;
    logic              row_more;
    logic [ADDR_W-1:0] pix_row;
    logic [ADDR_W-1:0] pix_col;
    logic              start_acc;
    logic              tmo_hit;

    assign col_more  = (win_col + ONE) < WIN_C;
    assign row_more  = (win_row + ONE) < WIN_R;
    assign start_acc = (state == IDLE) && bus.start;

`ifdef POOL_SCHED_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    // Down-counter loaded in POOL; reaching zero in WAIT_RDY without ready aborts the map.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == POOL) begin
                tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
            end else if (state == WAIT_RDY && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - TMO_W'(1);
            end
            if (state == WAIT_RDY && !bus.pool_ready && tmo_cnt == '0) begin
                err_q <= 1'b1;
            end
        end
    end

    assign tmo_hit = (tmo_cnt == '0);
    assign bus.err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        rd_k       = 2'd0;
        pool_start = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) next_state = RD0;
            end
            RD0: begin
                rd_en      = 1'b1;
                rd_k       = 2'd0;
                next_state = RD1;
            end
            RD1: begin
                rd_en      = 1'b1;
                rd_k       = 2'd1;
                next_state = RD2;
            end
            RD2: begin
                rd_en      = 1'b1;
                rd_k       = 2'd2;
                next_state = RD3;
            end
            RD3: begin
                rd_en      = 1'b1;
                rd_k       = 2'd3;
                next_state = LAST;
            end
            LAST: begin
                next_state = POOL;
            end
            POOL: begin
                pool_start = 1'b1;
                next_state = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (bus.pool_ready) begin
                    next_state = WR;
                end else if (tmo_hit) begin
                    next_state = FIN;
                end
            end
            WR: begin
                wr_en = 1'b1;
                if (col_more || row_more) begin
                    next_state = RD0;
                end else begin
                    next_state = FIN;
                end
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Window position advances on the write; it is only re-zeroed by the next start.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            win_row <= '0;
            win_col <= '0;
            out_idx <= '0;
        end else if (start_acc) begin
            win_row <= '0;
            win_col <= '0;
            out_idx <= '0;
        end else if (state == WR) begin
            out_idx <= out_idx + ONE;
            if (col_more) begin
                win_col <= win_col + ONE;
            end else begin
                win_col <= '0;
                win_row <= win_row + ONE;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            slot_vld_q <= 1'b0;
            slot_q     <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            slot_vld_q <= rd_en;
            slot_q     <= rd_k;
            done_q     <= (state == FIN);
            if (start_acc) begin
                busy_q <= 1'b1;
            end else if (state == FIN) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign pix_row = (win_row << 1) + ADDR_W'(rd_k[1]);
    assign pix_col = (win_col << 1) + ADDR_W'(rd_k[0]);

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.rd_en      = rd_en;
    assign bus.rd_addr    = rd_en ? (pix_row * W_A + pix_col) : '0;
    assign bus.slot       = slot_q;
    assign bus.slot_vld   = slot_vld_q;
    assign bus.pool_start = pool_start;
    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = wr_en ? out_idx : '0;

endmodule
